lcd_bus_receiver: RTL and testbench

//  Receive end of the 4-bit character-LCD bus driven by LCD_controler (oLCD_Data/Enabled/RegisterSelect/

---
 rtl/lcd_bus_receiver_pkg.sv | 36 +++
 rtl/lcd_bus_receiver_sync2.sv | 34 +++
 rtl/lcd_bus_receiver.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_receiver_pkg.sv
// -----------------------------------------------------------------------------
// lcd_bus_receiver_pkg
//   Shared definitions for the 4-bit character-LCD bus receiver: FSM state
//   encodings, sticky error bit indices, power-on init nibbles and the HD44780
//   command codes that the receiver decodes.
//   No ports (package).
// -----------------------------------------------------------------------------
package lcd_bus_receiver_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,   // waiting for the 3,3,3,2 wake-up / 4-bit-mode sequence
        ST_HI   = 2'd1,   // next nibble is the upper half of a byte
        ST_LO   = 2'd2    // next nibble is the lower half of a byte
    } state_t;

    localparam int ERR_W       = 5;
    localparam int ERR_EWIDTH  = 0;   // E high shorter than the minimum
    localparam int ERR_SETUP   = 1;   // Data/RS moved too close to E rising
    localparam int ERR_INIT    = 2;   // wrong nibble during the init sequence
    localparam int ERR_RSSPLIT = 3;   // RS differs between the two halves of a byte
    localparam int ERR_PROTO   = 4;   // RW=1 at capture, or SF_CE=0 at E rising

    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
    localparam logic [1:0] INIT_LAST_IDX = 2'd3;

    localparam logic [7:0] CMD_CLEAR       = 8'h01;
    localparam logic [7:0] CMD_HOME        = 8'h02;
    localparam int         CMD_SETADDR_BIT = 7;

    // Nibble expected at position idx of the init sequence: three wake-ups, then 0x2.
    function automatic logic [3:0] init_expected(input logic [1:0] idx);
        return (idx == INIT_LAST_IDX) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_sync2.sv
// -----------------------------------------------------------------------------
// lcd_bus_receiver_sync2
//   Parameterised-width two-flop synchronizer for asynchronous bus inputs.
//   Ports:
//     i_clk    in  1  sampling clock
//     i_rst_n  in  1  asynchronous active-low reset, clears both stages
//     i_d      in  W  asynchronous input vector
//     o_q      out W  synchronized vector (two clock edges of latency)
// -----------------------------------------------------------------------------
module lcd_bus_receiver_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// lcd_bus_receiver
//   Receive side of a 4-bit character-LCD bus. Rebuilds bytes from nibble pairs
//   after the 3,3,3,2 init sequence, decodes data bytes into a DDRAM write port
//   and tracks the DDRAM address through Set-Address / Clear / Home commands.
//   Bus timing and protocol violations are flagged in sticky error bits.
//   Ports:
//     Clock                    in  1       system clock (rising edge)
//     Reset                    in  1       asynchronous active-low reset
//     iLCD_Data                in  4       data nibble D7..D4
//     iLCD_Enabled             in  1       E strobe
//     iLCD_RegisterSelect      in  1       RS: 0 command, 1 data
//     iLCD_ReadWrite           in  1       RW, must be 0
//     iLCD_StrataFlashControl  in  1       SF_CE, must be 1 while the LCD is used
//     oByteValid               out 1       1-cycle strobe, oByte/oRS valid
//     oByte                    out 8       assembled byte
//     oRS                      out 1       RS of the assembled byte
//     oWrEn                    out 1       1-cycle DDRAM write strobe (data bytes)
//     oWrAddr                  out ADDR_W  DDRAM write address
//     oWrData                  out 8       DDRAM write data
//     oClear                   out 1       1-cycle strobe on Clear Display
//     oInitDone                out 1       init sequence seen, 4-bit mode active
//     oErr                     out 5       sticky errors {proto, rs split, init, setup, E width}
// -----------------------------------------------------------------------------
module lcd_bus_receiver
    import lcd_bus_receiver_pkg::*;
#(
    parameter int MIN_E_HIGH = 12,
    parameter int MIN_SETUP  = 2,
    parameter int ADDR_W     = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [3:0]        iLCD_Data,
    input  logic              iLCD_Enabled,
    input  logic              iLCD_RegisterSelect,
    input  logic              iLCD_ReadWrite,
    input  logic              iLCD_StrataFlashControl,
    output logic              oByteValid,
    output logic [7:0]        oByte,
    output logic              oRS,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [7:0]        oWrData,
    output logic              oClear,
    output logic              oInitDone,
    output logic [ERR_W-1:0]  oErr
);

    // Counters only need to reach their threshold, so they saturate there.
    localparam int CNT_MAX = (MIN_E_HIGH > MIN_SETUP) ? MIN_E_HIGH : MIN_SETUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 2) + 1;
    localparam logic [CNT_W-1:0] E_HIGH_MIN_C = CNT_W'(MIN_E_HIGH);
    localparam logic [CNT_W-1:0] SETUP_MIN_C  = CNT_W'(MIN_SETUP);

    // ---------------- input synchronization ----------------
    logic [7:0] w_raw;
    logic [7:0] w_sync;
    logic [3:0] w_s_data;
    logic       w_s_e;
    logic       w_s_rs;
    logic       w_s_rw;
    logic       w_s_sf;

    assign w_raw = {iLCD_StrataFlashControl, iLCD_ReadWrite, iLCD_RegisterSelect,
                    iLCD_Enabled, iLCD_Data};

    lcd_bus_receiver_sync2 #(.W(8)) u_sync (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_d     (w_raw),
        .o_q     (w_sync)
    );

    assign w_s_data = w_sync[3:0];
    assign w_s_e    = w_sync[4];
    assign w_s_rs   = w_sync[5];
    assign w_s_rw   = w_sync[6];
    assign w_s_sf   = w_sync[7];

    // ---------------- edge detection and timing counters ----------------
    // The *_d copies hold the previous synced cycle: on the E falling-edge cycle
    // they still carry the bus values seen while E was high.
    logic             r_e_d;
    logic [3:0]       r_data_d;
    logic             r_rs_d;
    logic             r_rw_d;
    logic [CNT_W-1:0] r_e_cnt;
    logic [CNT_W-1:0] r_stab_cnt;

    logic             w_e_rise;
    logic             w_e_fall;
    logic             w_bus_changed;
    logic [CNT_W-1:0] w_setup_cnt;

    assign w_e_rise      = w_s_e & ~r_e_d;
    assign w_e_fall      = ~w_s_e & r_e_d;
    assign w_bus_changed = ({w_s_data, w_s_rs} != {r_data_d, r_rs_d});
    // Cycles Data/RS have been stable up to and including the current cycle.
    assign w_setup_cnt   = w_bus_changed ? '0 : r_stab_cnt + 1'b1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_e_d      <= 1'b0;
            r_data_d   <= '0;
            r_rs_d     <= 1'b0;
            r_rw_d     <= 1'b0;
            r_e_cnt    <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_e_d    <= w_s_e;
            r_data_d <= w_s_data;
            r_rs_d   <= w_s_rs;
            r_rw_d   <= w_s_rw;
            // On the falling-edge cycle r_e_cnt equals the synced E high time.
            if (!w_s_e)
                r_e_cnt <= '0;
            else if (r_e_cnt < E_HIGH_MIN_C)
                r_e_cnt <= r_e_cnt + 1'b1;
            if (w_bus_changed)
                r_stab_cnt <= '0;
            else if (r_stab_cnt < SETUP_MIN_C)
                r_stab_cnt <= r_stab_cnt + 1'b1;
        end
    end

    // ---------------- FSM: state register ----------------
    state_t            r_state;
    logic [1:0]        r_init_idx;
    logic [3:0]        r_up_nib;
    logic              r_up_rs;
    logic [ADDR_W-1:0] r_addr;

    state_t            w_state_nx;
    logic [1:0]        w_init_idx_nx;
    logic [3:0]        w_up_nib_nx;
    logic              w_up_rs_nx;
    logic              w_init_err;
    logic              w_init_done_set;
    logic              w_nib_ok;

    // A nibble with RW=1 is flagged and dropped without moving the FSM.
    assign w_nib_ok = w_e_fall & ~r_rw_d;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
            r_up_nib   <= '0;
            r_up_rs    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_init_idx <= w_init_idx_nx;
            r_up_nib   <= w_up_nib_nx;
            r_up_rs    <= w_up_rs_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nx      = r_state;
        w_init_idx_nx   = r_init_idx;
        w_up_nib_nx     = r_up_nib;
        w_up_rs_nx      = r_up_rs;
        w_init_err      = 1'b0;
        w_init_done_set = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_nib_ok) begin
                    if (!r_rs_d && r_data_d == init_expected(r_init_idx)) begin
                        if (r_init_idx == INIT_LAST_IDX) begin
                            w_state_nx      = ST_HI;
                            w_init_idx_nx   = '0;
                            w_init_done_set = 1'b1;
                        end else begin
                            w_init_idx_nx = r_init_idx + 1'b1;
                        end
                    end else begin
                        w_init_err    = 1'b1;
                        w_init_idx_nx = '0;
                    end
                end
            end
            ST_HI: begin
                if (w_nib_ok) begin
                    w_up_nib_nx = r_data_d;
                    w_up_rs_nx  = r_rs_d;
                    w_state_nx  = ST_LO;
                end
            end
            ST_LO: begin
                if (w_nib_ok)
                    w_state_nx = ST_HI;
            end
            default: w_state_nx = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs / decode ----------------
    logic [7:0]        w_byte;
    logic              w_byte_vld;
    logic              w_wr_en;
    logic              w_clear;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [ERR_W-1:0]  w_err_set;

    always_comb begin
        w_byte     = {r_up_nib, r_data_d};
        w_byte_vld = (r_state == ST_LO) & w_nib_ok;
        // The lower half's RS decides whether this is data or a command.
        w_wr_en    = w_byte_vld & r_rs_d;
        w_clear    = w_byte_vld & ~r_rs_d & (w_byte == CMD_CLEAR);
        w_addr_nx  = r_addr;
        if (w_wr_en) begin
            w_addr_nx = r_addr + 1'b1;
        end else if (w_byte_vld && !r_rs_d) begin
            if (w_byte[CMD_SETADDR_BIT])
                w_addr_nx = ADDR_W'(w_byte[6:0]);
            else if (w_byte == CMD_CLEAR || w_byte == CMD_HOME)
                w_addr_nx = '0;
        end
        w_err_set              = '0;
        w_err_set[ERR_EWIDTH]  = w_e_fall & (r_e_cnt < E_HIGH_MIN_C);
        w_err_set[ERR_SETUP]   = w_e_rise & (w_setup_cnt < SETUP_MIN_C);
        w_err_set[ERR_INIT]    = w_init_err;
        w_err_set[ERR_RSSPLIT] = w_byte_vld & (r_up_rs != r_rs_d);
        w_err_set[ERR_PROTO]   = (w_e_fall & r_rw_d) | (w_e_rise & ~w_s_sf);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_addr     <= '0;
            oByteValid <= 1'b0;
            oByte      <= '0;
            oRS        <= 1'b0;
            oWrEn      <= 1'b0;
            oWrAddr    <= '0;
            oWrData    <= '0;
            oClear     <= 1'b0;
            oInitDone  <= 1'b0;
            oErr       <= '0;
        end else begin
            r_addr     <= w_addr_nx;
            oByteValid <= w_byte_vld;
            oWrEn      <= w_wr_en;
            oClear     <= w_clear;
            oErr       <= oErr | w_err_set;
            if (w_byte_vld) begin
                oByte <= w_byte;
                oRS   <= r_rs_d;
            end
            if (w_wr_en) begin
                oWrAddr <= r_addr;
                oWrData <= w_byte;
            end
            if (w_init_done_set)
                oInitDone <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_receiver
//   Directed bench for lcd_bus_receiver: drives the 4-bit LCD bus like the
//   controller would and checks decoded bytes, DDRAM writes and error flags.
// -----------------------------------------------------------------------------
module tb_lcd_bus_receiver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] iLCD_Data;
    logic       iLCD_Enabled;
    logic       iLCD_RegisterSelect;
    logic       iLCD_ReadWrite;
    logic       iLCD_StrataFlashControl;
    logic       oByteValid;
    logic [7:0] oByte;
    logic       oRS;
    logic       oWrEn;
    logic [6:0] oWrAddr;
    logic [7:0] oWrData;
    logic       oClear;
    logic       oInitDone;
    logic [4:0] oErr;

    always #5 Clock = ~Clock;

    lcd_bus_receiver u_dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iLCD_Data               (iLCD_Data),
        .iLCD_Enabled            (iLCD_Enabled),
        .iLCD_RegisterSelect     (iLCD_RegisterSelect),
        .iLCD_ReadWrite          (iLCD_ReadWrite),
        .iLCD_StrataFlashControl (iLCD_StrataFlashControl),
        .oByteValid              (oByteValid),
        .oByte                   (oByte),
        .oRS                     (oRS),
        .oWrEn                   (oWrEn),
        .oWrAddr                 (oWrAddr),
        .oWrData                 (oWrData),
        .oClear                  (oClear),
        .oInitDone               (oInitDone),
        .oErr                    (oErr)
    );

    int checks   = 0;
    int failures = 0;

    // Observation of the 1-cycle strobes, sampled 1 time unit after each edge.
    int         cyc      = 0;
    int         nbv      = 0;
    int         nwr      = 0;
    int         nclr     = 0;
    int         wide     = 0;
    int         bv_cyc   = 0;
    int         wr_cyc   = 0;
    int         fall_cyc = 0;
    logic [7:0] last_byte  = '0;
    logic       last_rs    = 1'b0;
    logic [6:0] last_waddr = '0;
    logic [7:0] last_wdata = '0;
    logic       prev_bv    = 1'b0;
    logic       prev_wr    = 1'b0;

    always @(posedge Clock) begin
        cyc = cyc + 1;
        #1;
        if (oByteValid) begin
            nbv       = nbv + 1;
            last_byte = oByte;
            last_rs   = oRS;
            bv_cyc    = cyc;
        end
        if (oWrEn) begin
            nwr        = nwr + 1;
            last_waddr = oWrAddr;
            last_wdata = oWrData;
            wr_cyc     = cyc;
        end
        if (oClear)
            nclr = nclr + 1;
        if ((oByteValid && prev_bv) || (oWrEn && prev_wr))
            wide = wide + 1;
        prev_bv = oByteValid;
        prev_wr = oWrEn;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // One nibble: 4 cycles setup, eh cycles E high, 4 cycles hold.
    task automatic send_nib(input logic [3:0] d, input logic r, input int eh, input logic w);
        iLCD_Data           = d;
        iLCD_RegisterSelect = r;
        iLCD_ReadWrite      = w;
        repeat (4) tick();
        iLCD_Enabled = 1'b1;
        repeat (eh) tick();
        iLCD_Enabled = 1'b0;
        fall_cyc = cyc;
        repeat (4) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        send_nib(b[7:4], r, 12, 1'b0);
        send_nib(b[3:0], r, 12, 1'b0);
    endtask

    task automatic do_init();
        send_nib(4'h3, 1'b0, 12, 1'b0);
        send_nib(4'h3, 1'b0, 12, 1'b0);
        send_nib(4'h3, 1'b0, 12, 1'b0);
        send_nib(4'h2, 1'b0, 12, 1'b0);
    endtask

    // Asserts Reset between clock edges and checks the outputs cleared without an edge.
    task automatic do_reset(input string tag);
        #3;
        Reset = 1'b0;
        #1;
        check({tag, "_initdone"}, 32'(oInitDone), 32'd0);
        check({tag, "_err"},      32'(oErr),      32'd0);
        check({tag, "_waddr"},    32'(oWrAddr),   32'd0);
        check({tag, "_byte"},     32'(oByte),     32'd0);
        repeat (3) tick();
        Reset = 1'b1;
        repeat (4) tick();
    endtask

    int n0;
    int w0;

    initial begin
        Reset                   = 1'b0;
        iLCD_Data               = 4'h0;
        iLCD_Enabled            = 1'b0;
        iLCD_RegisterSelect     = 1'b0;
        iLCD_ReadWrite          = 1'b0;
        iLCD_StrataFlashControl = 1'b1;
        tick();
        check("rst_bv",       32'(oByteValid), 32'd0);
        check("rst_wren",     32'(oWrEn),      32'd0);
        check("rst_clear",    32'(oClear),     32'd0);
        check("rst_initdone", 32'(oInitDone),  32'd0);
        check("rst_err",      32'(oErr),       32'd0);
        check("rst_waddr",    32'(oWrAddr),    32'd0);
        repeat (2) tick();
        Reset = 1'b1;
        repeat (4) tick();

        // 1: init then Function Set 0x28
        do_init();
        check("t1_initdone", 32'(oInitDone), 32'd1);
        check("t1_nbv_init", 32'(nbv),       32'd0);
        send_byte(8'h28, 1'b0);
        check("t1_nbv",     32'(nbv),              32'd1);
        check("t1_byte",    32'(last_byte),        32'h28);
        check("t1_rs",      32'(last_rs),          32'd0);
        check("t1_err",     32'(oErr),             32'd0);
        check("t1_latency", 32'(bv_cyc - fall_cyc), 32'd3);

        // 2: Set address 0x40, then two data bytes
        send_byte(8'hC0, 1'b0);
        check("t2_nwr_cmd", 32'(nwr), 32'd0);
        send_byte(8'h41, 1'b1);
        check("t2_nwr1",   32'(nwr),                32'd1);
        check("t2_waddr1", 32'(last_waddr),         32'h40);
        check("t2_wdata1", 32'(last_wdata),         32'h41);
        check("t2_wr_lat", 32'(wr_cyc - fall_cyc),  32'd3);
        send_byte(8'h42, 1'b1);
        check("t2_nwr2",   32'(nwr),        32'd2);
        check("t2_waddr2", 32'(last_waddr), 32'h41);
        check("t2_wdata2", 32'(last_wdata), 32'h42);

        // 3: address wrap and Clear Display
        send_byte(8'hFF, 1'b0);
        send_byte(8'h55, 1'b1);
        check("t3_waddr_7f", 32'(last_waddr), 32'h7F);
        check("t3_wdata_55", 32'(last_wdata), 32'h55);
        send_byte(8'h66, 1'b1);
        check("t3_waddr_wrap", 32'(last_waddr), 32'h00);
        check("t3_wdata_66",   32'(last_wdata), 32'h66);
        send_byte(8'h42, 1'b1);
        check("t3_waddr_01", 32'(last_waddr), 32'h01);
        check("t3_nclr0", 32'(nclr), 32'd0);
        send_byte(8'h01, 1'b0);
        check("t3_nclr1", 32'(nclr), 32'd1);
        send_byte(8'h77, 1'b1);
        check("t3_waddr_clr", 32'(last_waddr), 32'h00);
        check("t3_wdata_77",  32'(last_wdata), 32'h77);
        check("t3_err",       32'(oErr),       32'd0);

        // 4: short E, RS split, RW=1 nibble
        w0 = nwr;
        send_nib(4'h5, 1'b1, 5, 1'b0);
        send_nib(4'h8, 1'b1, 12, 1'b0);
        check("t4_short_nwr",   32'(nwr),        32'(w0 + 1));
        check("t4_short_waddr", 32'(last_waddr), 32'h01);
        check("t4_short_wdata", 32'(last_wdata), 32'h58);
        check("t4_short_err",   32'(oErr),       32'b00001);
        send_nib(4'h4, 1'b0, 12, 1'b0);
        send_nib(4'h3, 1'b1, 12, 1'b0);
        check("t4_split_byte",  32'(last_byte),  32'h43);
        check("t4_split_rs",    32'(last_rs),    32'd1);
        check("t4_split_waddr", 32'(last_waddr), 32'h02);
        check("t4_split_err",   32'(oErr),       32'b01001);
        n0 = nbv;
        send_nib(4'h9, 1'b0, 12, 1'b1);
        check("t4_rw_err", 32'(oErr), 32'b11001);
        check("t4_rw_nbv", 32'(nbv),  32'(n0));
        send_byte(8'h20, 1'b0);
        check("t4_rw_after_nbv",  32'(nbv),       32'(n0 + 1));
        check("t4_rw_after_byte", 32'(last_byte), 32'h20);

        // 5: bad first init nibble, then a good sequence
        do_reset("t5_rst");
        send_nib(4'h2, 1'b0, 12, 1'b0);
        check("t5_bad_err",      32'(oErr),      32'b00100);
        check("t5_bad_initdone", 32'(oInitDone), 32'd0);
        do_init();
        check("t5_initdone", 32'(oInitDone), 32'd1);
        check("t5_err_keep", 32'(oErr),      32'b00100);

        // 6: reset after an upper nibble drops it; full init needed again
        send_nib(4'h4, 1'b1, 12, 1'b0);
        do_reset("t6_rst");
        do_init();
        w0 = nwr;
        send_byte(8'h41, 1'b1);
        check("t6_nwr",    32'(nwr),               32'(w0 + 1));
        check("t6_waddr",  32'(last_waddr),        32'h00);
        check("t6_wdata",  32'(last_wdata),        32'h41);
        check("t6_wr_lat", 32'(wr_cyc - fall_cyc), 32'd3);
        check("t6_err",    32'(oErr),              32'd0);

        check("strobe_width", 32'(wide), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
